// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter that shares one D$ request port among NR_PORTS LSU-side requesters.
// The selected requester stays locked until granted; responses are routed back in order via an ID FIFO.
module dcache_port_arbiter #(
  parameter int unsigned NR_PORTS  = 2,
  parameter int unsigned ADDR_W    = 56,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NR_PORTS-1:0]              req_i,
  input  logic [NR_PORTS-1:0]              we_i,
  input  logic [NR_PORTS*ADDR_W-1:0]       addr_i,
  input  logic [NR_PORTS*DATA_W-1:0]       wdata_i,
  input  logic [NR_PORTS*8-1:0]            be_i,
  input  logic [NR_PORTS*2-1:0]            size_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                rdata_o,
  output logic                             req_o,
  output logic                             we_o,
  output logic [ADDR_W-1:0]                addr_o,
  output logic [DATA_W-1:0]                wdata_o,
  output logic [7:0]                       be_o,
  output logic [1:0]                       size_o,
  input  logic                             gnt_i,
  input  logic                             rvalid_i,
  input  logic [DATA_W-1:0]                rdata_i,
  output logic [$clog2(MAX_OUTST):0]       outstanding_o,
  output logic                             unexp_rsp_o
);

  localparam int unsigned SEL_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   id_mem_q [MAX_OUTST];

  logic [SEL_W-1:0]   scan_idx;
  logic [SEL_W-1:0]   cand_sel;
  logic               cand_vld;
  logic [SEL_W-1:0]   cur_sel;
  logic [SEL_W-1:0]   head_id;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant;
  logic               push;
  logic               pop;

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = id_mem_q[rptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    scan_idx = '0;
    cand_sel = '0;
    cand_vld = 1'b0;
    // First set request at or above the rr pointer, wrapping around.
    for (int i = 0; i < NR_PORTS; i++) begin
      scan_idx = SEL_W'((32'(rr_q) + 32'(i)) % NR_PORTS);
      if (!cand_vld && req_i[scan_idx]) begin
        cand_vld = 1'b1;
        cand_sel = scan_idx;
      end
    end
  end

  always_comb begin
    cur_sel = (state_q == LOCKED) ? sel_q : cand_sel;
    req_o   = (state_q == LOCKED) || (!flush_i && !fifo_full && cand_vld);
    grant   = req_o && gnt_i;
    push    = grant;
    pop     = rvalid_i && !fifo_empty;

    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = '0;
    size_o  = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      gnt_o[i]    = grant && (cur_sel == SEL_W'(i));
      rvalid_o[i] = pop && (head_id == SEL_W'(i));
      if (req_o && (cur_sel == SEL_W'(i))) begin
        we_o    = we_i[i];
        addr_o  = addr_i[i*ADDR_W +: ADDR_W];
        wdata_o = wdata_i[i*DATA_W +: DATA_W];
        be_o    = be_i[i*8 +: 8];
        size_o  = size_i[i*2 +: 2];
      end
    end

    rdata_o       = rdata_i;
    unexp_rsp_o   = rvalid_i && fifo_empty;
    outstanding_o = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (grant) begin
      rr_d = (cur_sel == SEL_W'(NR_PORTS - 1)) ? '0 : cur_sel + SEL_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (req_o && !gnt_i) begin
          state_d = LOCKED;
          sel_d   = cand_sel;
        end
      end
      LOCKED: begin
        if (gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the ID storage is not reset; entries are only read below the fill level, which is reset.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wptr_q] <= cur_sel;
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_dcache_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic [NP-1:0]   req_i, we_i;
  logic [NP*AW-1:0] addr_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP*8-1:0] be_i;
  logic [NP*2-1:0] size_i;
  logic [NP-1:0]   gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            req_o, we_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   wdata_o;
  logic [7:0]      be_o;
  logic [1:0]      size_o;
  logic            gnt_i, rvalid_i;
  logic [DW-1:0]   rdata_i;
  logic [2:0]      outstanding_o;
  logic            unexp_rsp_o;

  dcache_port_arbiter #(.NR_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side: a pending request keeps its payload until granted.
  bit          pending [NP];
  logic        p_we    [NP];
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_wdata[NP];
  logic [7:0]  p_be    [NP];
  logic [1:0]  p_size  [NP];

  // Reference model: outstanding grants as a queue of port ids, plus lock and rr state.
  int id_q[$];
  bit locked;
  int lock_port;
  int rr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_payload(input int i);
    p_we[i]    = 1'($urandom);
    p_addr[i]  = AW'({$urandom, $urandom});
    p_wdata[i] = {$urandom, $urandom};
    p_be[i]    = 8'($urandom);
    p_size[i]  = 2'($urandom);
  endtask

  task automatic req_port(input int i);
    pending[i] = 1'b1;
    rand_payload(i);
  endtask

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      req_i[i]            = pending[i];
      we_i[i]             = p_we[i];
      addr_i[i*AW +: AW]  = p_addr[i];
      wdata_i[i*DW +: DW] = p_wdata[i];
      be_i[i*8 +: 8]      = p_be[i];
      size_i[i*2 +: 2]    = p_size[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    for (int i = 0; i < NP; i++) begin
      pending[i] = 1'b0;
      rand_payload(i);
    end
    drive_ports();
    #1;
    check("rst_req", req_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rvalid_rst", rvalid_o, 0);
    check("rst_outst", outstanding_o, 0);
    check("rst_unexp", unexp_rsp_o, 0);
    check("rst_addr", addr_o, 0);
    id_q.delete();
    locked    = 1'b0;
    lock_port = 0;
    rr        = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs after the edge, compare mid-cycle, then advance the model.
  task automatic step(input bit g, input bit rv, input bit fl);
    int sel;
    bit ereq, grant, pop;
    logic [NP-1:0] egnt, ervld;
    logic [DW-1:0] rd;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < NP; i++) if (!pending[i]) rand_payload(i);
    drive_ports();
    rd       = {$urandom, $urandom};
    gnt_i    = g;
    rvalid_i = rv;
    flush_i  = fl;
    rdata_i  = rd;
    #3;
    ereq = 1'b0;
    sel  = 0;
    if (locked) begin
      ereq = 1'b1;
      sel  = lock_port;
    end else if (!fl && id_q.size() < MO) begin
      for (int k = 0; k < NP; k++) begin
        if (!ereq && pending[(rr + k) % NP]) begin
          ereq = 1'b1;
          sel  = (rr + k) % NP;
        end
      end
    end
    grant = ereq && g;
    egnt  = grant ? (NP'(1) << sel) : '0;
    pop   = rv && (id_q.size() > 0);
    ervld = pop ? (NP'(1) << id_q[0]) : '0;

    check("req_o", req_o, ereq);
    check("gnt_o", gnt_o, egnt);
    check("rvalid_o", rvalid_o, ervld);
    check("rdata_o", rdata_o, rd);
    check("unexp", unexp_rsp_o, rv && (id_q.size() == 0));
    check("outst", outstanding_o, id_q.size());
    check("we_o", we_o, ereq ? p_we[sel] : 1'b0);
    check("addr_o", addr_o, ereq ? p_addr[sel] : '0);
    check("wdata_o", wdata_o, ereq ? p_wdata[sel] : '0);
    check("be_o", be_o, ereq ? p_be[sel] : '0);
    check("size_o", size_o, ereq ? p_size[sel] : '0);

    if (pop) void'(id_q.pop_front());
    if (grant) begin
      id_q.push_back(sel);
      rr           = (sel + 1) % NP;
      locked       = 1'b0;
      pending[sel] = 1'b0;
    end else if (ereq && !locked) begin
      locked    = 1'b1;
      lock_port = sel;
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    req_i    = '0;
    we_i     = '0;
    addr_i   = '0;
    wdata_i  = '0;
    be_i     = '0;
    size_i   = '0;
    do_reset();

    // Single request granted in the same cycle, response two cycles later.
    req_port(0);
    step(1, 0, 0);
    check("s1_gnt", gnt_o, 2'b01);
    check("s1_req", req_o, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    check("s1_rvalid", rvalid_o, 2'b01);
    check("s1_outst_pre", outstanding_o, 1);
    step(0, 0, 0);
    check("s1_outst_post", outstanding_o, 0);

    // Both ports requesting, gnt every cycle: alternation, then FIFO full backpressure.
    do_reset();
    req_port(0);
    req_port(1);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      check("s2_rr_gnt", gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < NP; i++) if (!pending[i]) req_port(i);
    end
    step(1, 0, 0);
    check("s2_full_req", req_o, 0);
    check("s2_full_outst", outstanding_o, 4);
    step(0, 1, 0);
    check("s2_pop_rvalid", rvalid_o, 2'b01);
    check("s2_pop_req", req_o, 0);
    step(0, 0, 0);
    check("s2_reassert", req_o, 1);

    // Lock holds port 0's payload while port 1 also requests.
    do_reset();
    req_port(0);
    step(0, 0, 0);
    check("s3_addr_c1", addr_o, p_addr[0]);
    req_port(1);
    step(0, 0, 0);
    check("s3_addr_c2", addr_o, p_addr[0]);
    step(0, 0, 0);
    check("s3_addr_c3", addr_o, p_addr[0]);
    step(1, 0, 0);
    check("s3_gnt0", gnt_o, 2'b01);
    step(1, 0, 0);
    check("s3_gnt1", gnt_o, 2'b10);

    // Interleaved grants 0,1,0 with delayed in-order responses.
    do_reset();
    req_port(0);
    step(1, 0, 0);
    req_port(1);
    step(1, 0, 0);
    req_port(0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("s5_rv0", rvalid_o, 2'b01);
    step(0, 0, 0);
    step(0, 1, 0);
    check("s5_rv1", rvalid_o, 2'b10);
    step(0, 1, 0);
    check("s5_rv2", rvalid_o, 2'b01);

    // Flush while locked completes; flush in idle blocks; unexpected response pulse.
    do_reset();
    req_port(0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("s6_locked_flush_req", req_o, 1);
    step(1, 0, 1);
    check("s6_locked_flush_gnt", gnt_o, 2'b01);
    req_port(1);
    step(0, 0, 1);
    check("s6_idle_flush_req", req_o, 0);
    step(0, 1, 0);
    check("s6_unexp_none", unexp_rsp_o, 0);
    step(0, 1, 0);
    check("s6_unexp_pulse", unexp_rsp_o, 1);
    step(0, 0, 0);
    check("s6_unexp_clear", unexp_rsp_o, 0);

    // Randomized traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 3000; n++) begin
      bit g, rv, fl;
      if (n == 1500) do_reset();
      for (int i = 0; i < NP; i++) if (!pending[i] && $urandom_range(0, 9) < 4) req_port(i);
      g  = ($urandom_range(0, 1) == 1);
      rv = (id_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(g, rv, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
